// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// --------------------
// Central hazard controller for the 5-stage RV32E pipeline.
//   * Drives enable/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//     registers and the PC enable (combinational, zero latency).
//   * Detects load-use hazards (1-cycle bubble), squashes the two wrong-path
//     instructions on a taken branch, and freezes the pipe while data memory
//     is not ready.
//   * Produces the EX-stage operand forwarding selects
//     (00 = register file, 01 = MEM/WB, 10 = EX/MEM).
//   * A watchdog halts the core after TIMEOUT consecutive memory wait cycles
//     in MEM_WAIT, raising a sticky mem_timeout.
//   * stall_cycles counts cycles in which the PC was held in RUN/MEM_WAIT.
//
// Ports
//   clk, rst (async, active-low)
//   id_*   : source operands of the instruction in ID
//   ex_*   : source/destination operands, load flag and branch result in EX
//   mem_*  : destination register / write flag in MEM, data memory handshake
//   wb_*   : destination register / write flag in WB
//   stall_clear : synchronous clear of stall_cycles
//   *_enable / *_flush : pipeline register controls
//   fwd_a_sel, fwd_b_sel : EX operand forwarding selects
//   mem_timeout : sticky watchdog flag
//   stall_cycles : saturating stall-cycle counter
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_rs1_addr,
  input  logic [3:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [3:0]       ex_rs1_addr,
  input  logic [3:0]       ex_rs2_addr,
  input  logic [3:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [3:0]       mem_rd_addr,
  input  logic             mem_reg_write,
  input  logic [3:0]       wb_rd_addr,
  input  logic             wb_reg_write,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             stall_clear,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_flush,
  output logic             ex_mem_enable,
  output logic             ex_mem_flush,
  output logic             mem_wb_enable,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic               mem_timeout_reg, mem_timeout_next;
  logic [CNT_W-1:0]   stall_cycles_reg, stall_cycles_next;

  logic lu;
  logic mw;
  logic active;

  // Hazard conditions. A load into x0 never creates a dependency.
  assign lu = ex_mem_read && (ex_rd_addr != 4'd0) &&
              ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
               (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
  // mem_ready without an outstanding request is meaningless and ignored.
  assign mw     = mem_req && !mem_ready;
  assign active = (state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT);

  // ---------------------------------------------------------------------------
  // Forwarding: one identical selector per EX operand. EX/MEM is the younger
  // producer and therefore wins over MEM/WB; x0 is never forwarded.
  // ---------------------------------------------------------------------------
  logic [3:0] ex_src_addr [2];
  logic [1:0] fwd_sel     [2];

  assign ex_src_addr[0] = ex_rs1_addr;
  assign ex_src_addr[1] = ex_rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (mem_reg_write && (mem_rd_addr != 4'd0) && (mem_rd_addr == ex_src_addr[gi]))
          fwd_sel[gi] = 2'b10;
        else if (wb_reg_write && (wb_rd_addr != 4'd0) && (wb_rd_addr == ex_src_addr[gi]))
          fwd_sel[gi] = 2'b01;
      end
    end
  endgenerate

  assign fwd_a_sel = fwd_sel[0];
  assign fwd_b_sel = fwd_sel[1];

  // ---------------------------------------------------------------------------
  // Pipeline controls. Memory wait dominates: EX is held, so a pending branch
  // or load-use in EX is simply re-evaluated once memory completes.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_enable     = 1'b0;
    if_id_enable  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_enable = 1'b0;
    mem_wb_flush  = 1'b0;
    if (active) begin
      if (mw) begin
        // Front of the pipe frozen; a bubble drains into WB.
        mem_wb_enable = 1'b1;
        mem_wb_flush  = 1'b1;
      end else if (ex_branch_taken) begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
      end else if (lu) begin
        // Hold IF and ID, insert a bubble into EX while the load advances.
        id_ex_enable  = 1'b1;
        id_ex_flush   = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
      end else begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and watchdog
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_INIT:     state_next = ST_RUN;
      ST_RUN:      if (mw) state_next = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (!mw)
          state_next = ST_RUN;
        else if (wait_cnt_reg == WAIT_LAST)
          state_next = ST_HALT;
      end
      ST_HALT:     state_next = ST_HALT;
      default:     state_next = ST_INIT;
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!mw)
      wait_cnt_next = '0;
    else if (state_reg == ST_MEM_WAIT)
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
  end

  assign mem_timeout_next = mem_timeout_reg ||
                            ((state_next == ST_HALT) && (state_reg != ST_HALT));

  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    if (stall_clear)
      stall_cycles_next = '0;
    else if (active && !pc_enable && (stall_cycles_reg != CNT_MAX))
      stall_cycles_next = stall_cycles_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_INIT;
      wait_cnt_reg     <= '0;
      mem_timeout_reg  <= 1'b0;
      stall_cycles_reg <= '0;
    end else begin
      state_reg        <= state_next;
      wait_cnt_reg     <= wait_cnt_next;
      mem_timeout_reg  <= mem_timeout_next;
      stall_cycles_reg <= stall_cycles_next;
    end
  end

  assign mem_timeout  = mem_timeout_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=4 so that the
// watchdog and counter saturation are reached in a few cycles).
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  // Control vector order:
  // {pc, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, ex_mem_fl, mem_wb_en, mem_wb_fl}
  localparam logic [8:0] C_OFF    = 9'b0_00_00_00_00;
  localparam logic [8:0] C_NORMAL = 9'b1_10_10_10_10;
  localparam logic [8:0] C_MW     = 9'b0_00_00_00_11;
  localparam logic [8:0] C_BR     = 9'b1_11_11_10_10;
  localparam logic [8:0] C_LU     = 9'b0_00_11_10_10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [3:0] mem_rd_addr, wb_rd_addr;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic mem_reg_write, wb_reg_write, mem_req, mem_ready, stall_clear;
  logic pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush;
  logic ex_mem_enable, ex_mem_flush, mem_wb_enable, mem_wb_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .mem_req(mem_req), .mem_ready(mem_ready), .stall_clear(stall_clear),
    .pc_enable(pc_enable),
    .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .id_ex_enable(id_ex_enable), .id_ex_flush(id_ex_flush),
    .ex_mem_enable(ex_mem_enable), .ex_mem_flush(ex_mem_flush),
    .mem_wb_enable(mem_wb_enable), .mem_wb_flush(mem_wb_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  wire [8:0] ctrl = {pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
                     ex_mem_enable, ex_mem_flush, mem_wb_enable, mem_wb_flush};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %-14s observed=0x%0h expected=0x%0h @%0t", tag, observed, expected, $time);
    end else begin
      $display("ok   %-14s value=0x%0h @%0t", tag, observed, $time);
    end
  endtask

  task automatic idle_inputs();
    id_rs1_addr = 4'd0; id_rs2_addr = 4'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1_addr = 4'd0; ex_rs2_addr = 4'd0; ex_rd_addr = 4'd0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_rd_addr = 4'd0; mem_reg_write = 1'b0; wb_rd_addr = 4'd0; wb_reg_write = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; stall_clear = 1'b0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rd_addr = 4'd5; id_rs2_addr = 4'd5; id_uses_rs2 = 1'b1;
  endtask

  // Advance one clock and leave inputs open for the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    idle_inputs();
    // ---------------- reset ----------------
    settle();
    check("rst_ctrl", 32'(ctrl), 32'(C_OFF));
    check("rst_stall", 32'(stall_cycles), 32'd0);
    check("rst_tmo", 32'(mem_timeout), 32'd0);
    check("rst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
    step(); step();
    rst = 1'b1;                 // release between edges; INIT for one cycle
    settle();
    check("init_frozen", 32'(ctrl), 32'(C_OFF));
    step();                     // INIT -> RUN
    settle();
    check("run_normal", 32'(ctrl), 32'(C_NORMAL));
    check("init_nocount", 32'(stall_cycles), 32'd0);

    // ---------------- load-use ----------------
    set_lu();
    settle();
    check("lu_ctrl", 32'(ctrl), 32'(C_LU));
    step();
    idle_inputs();              // load has moved to MEM
    settle();
    check("lu_after", 32'(ctrl), 32'(C_NORMAL));
    check("lu_stall_cnt", 32'(stall_cycles), 32'd1);

    set_lu(); ex_rd_addr = 4'd0; id_rs2_addr = 4'd0;
    settle();
    check("lu_x0", 32'(ctrl), 32'(C_NORMAL));
    set_lu(); id_uses_rs2 = 1'b0;
    settle();
    check("lu_nouse", 32'(ctrl), 32'(C_NORMAL));
    id_rs1_addr = 4'd5; id_uses_rs1 = 1'b1;
    settle();
    check("lu_rs1", 32'(ctrl), 32'(C_LU));
    step();
    idle_inputs();
    settle();
    check("lu_rs1_cnt", 32'(stall_cycles), 32'd2);

    // ---------------- branch beats load-use ----------------
    set_lu(); ex_branch_taken = 1'b1;
    settle();
    check("br_lu", 32'(ctrl), 32'(C_BR));
    step();
    idle_inputs();
    settle();
    check("br_nocount", 32'(stall_cycles), 32'd2);

    // ---------------- stall_clear ----------------
    stall_clear = 1'b1;
    step();
    stall_clear = 1'b0;
    settle();
    check("clear", 32'(stall_cycles), 32'd0);

    // mem_ready without mem_req is ignored
    mem_ready = 1'b1;
    settle();
    check("rdy_noreq", 32'(ctrl), 32'(C_NORMAL));

    // ---------------- memory wait with pending branch ----------------
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("mw_%0d", i), 32'(ctrl), 32'(C_MW));
      step();
    end
    mem_ready = 1'b1;
    settle();
    check("mw_done_br", 32'(ctrl), 32'(C_BR));
    check("mw_cnt", 32'(stall_cycles), 32'd3);
    step();
    idle_inputs();
    settle();
    check("mw_back_run", 32'(ctrl), 32'(C_NORMAL));
    check("mw_no_tmo", 32'(mem_timeout), 32'd0);

    // ---------------- stall counter saturation (CNT_W=4) ----------------
    set_lu();
    for (int i = 0; i < 13; i++) step();
    settle();
    check("sat", 32'(stall_cycles), 32'd15);
    idle_inputs();
    stall_clear = 1'b1;
    step();
    stall_clear = 1'b0;

    // ---------------- forwarding ----------------
    mem_reg_write = 1'b1; mem_rd_addr = 4'd3; wb_reg_write = 1'b1; wb_rd_addr = 4'd3;
    ex_rs1_addr = 4'd3; ex_rs2_addr = 4'd3;
    settle();
    check("fwd_exmem", 32'({fwd_a_sel, fwd_b_sel}), 32'b10_10);
    mem_rd_addr = 4'd0;
    settle();
    check("fwd_memwb", 32'({fwd_a_sel, fwd_b_sel}), 32'b01_01);
    wb_rd_addr = 4'd0; ex_rs1_addr = 4'd0; ex_rs2_addr = 4'd0;
    settle();
    check("fwd_x0", 32'({fwd_a_sel, fwd_b_sel}), 32'b00_00);
    ex_rs1_addr = 4'd3; ex_rs2_addr = 4'd7; mem_rd_addr = 4'd7; wb_rd_addr = 4'd3;
    settle();
    check("fwd_mix", 32'({fwd_a_sel, fwd_b_sel}), 32'b01_10);
    mem_reg_write = 1'b0; mem_rd_addr = 4'd3;
    settle();
    check("fwd_nowr", 32'({fwd_a_sel, fwd_b_sel}), 32'b01_00);
    idle_inputs();

    // ---------------- watchdog ----------------
    // 1 RUN cycle + TIMEOUT MEM_WAIT cycles frozen, then HALT.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 1 + TIMEOUT; i++) begin
      settle();
      check($sformatf("wd_wait_%0d", i), 32'({ctrl, mem_timeout}), 32'({C_MW, 1'b0}));
      step();
    end
    settle();
    check("halt_ctrl", 32'(ctrl), 32'(C_OFF));
    check("halt_tmo", 32'(mem_timeout), 32'd1);
    check("halt_cnt", 32'(stall_cycles), 32'd5);
    idle_inputs();
    step(); step();
    settle();
    check("halt_stays", 32'({ctrl, mem_timeout}), 32'({C_OFF, 1'b1}));
    check("halt_nocount", 32'(stall_cycles), 32'd5);

    // ---------------- asynchronous reset mid-operation ----------------
    #2 rst = 1'b0;
    #1;
    check("arst_tmo", 32'(mem_timeout), 32'd0);
    check("arst_cnt", 32'(stall_cycles), 32'd0);
    check("arst_ctrl", 32'(ctrl), 32'(C_OFF));
    step();
    rst = 1'b1;
    step();
    settle();
    check("arst_run", 32'(ctrl), 32'(C_NORMAL));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
